// File: rtl/mp3_pkg.sv
// Shared command codes, player state encoding and decoded-command bundle
// used by the player, the IR decoder and the display block.
package mp3_pkg;

    localparam logic [7:0] CMD_MUTE = 8'h00;
    localparam logic [7:0] CMD_PLAY = 8'h01;
    localparam logic [7:0] CMD_NEXT = 8'h02;
    localparam logic [7:0] CMD_STOP = 8'h03;
    localparam logic [7:0] CMD_PREV = 8'h04;
    localparam logic [7:0] CMD_LOOP = 8'h05;
    localparam logic [7:0] CMD_NONE = 8'hFF;

    typedef enum logic [2:0] {
        ST_STOPPED = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_NOTE    = 3'd3,
        ST_PAUSED  = 3'd4
    } state_t;

    typedef struct packed {
        logic do_mute;
        logic do_play;
        logic do_next;
        logic do_stop;
        logic do_prev;
        logic do_loop;
    } cmd_t;

    localparam cmd_t CMD_IDLE = '0;

endpackage

// File: rtl/mp3_seq_player_tone_gen.sv
// Half-period square-wave generator; clears on load, freezes while disabled.
module tone_gen #(
    parameter int PER_W = 18
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [PER_W-1:0] period,
    output logic             tone_q
);

    logic [PER_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset || load) begin
            cnt    <= '0;
            tone_q <= 1'b0;
        end else if (enable) begin
            // a zero period is a rest: hold the output low
            if (period == '0) begin
                cnt    <= '0;
                tone_q <= 1'b0;
            end else if (cnt == period - PER_W'(1)) begin
                cnt    <= '0;
                tone_q <= ~tone_q;
            end else begin
                cnt <= cnt + PER_W'(1);
            end
        end
    end

endmodule

// File: rtl/mp3_seq_player.sv
// Multi-track player controller: edge-detected button commands, note-table
// sequencing through an external 1-clock ROM, and buzzer tone drive.
module mp3_seq_player
    import mp3_pkg::*;
#(
    parameter int NUM_TRACKS = 4,
    parameter int TRK_W      = 2,
    parameter int IDX_W      = 6,
    parameter int PER_W      = 18,
    parameter int DUR_W      = 6,
    parameter int TICK_DIV   = 2500000,
    parameter int BTN_W      = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [BTN_W-1:0]       bot,
    output logic [TRK_W+IDX_W-1:0] rom_addr,
    input  logic [PER_W+DUR_W-1:0] rom_data,
    output logic                   buzzer,
    output logic [TRK_W-1:0]       track,
    output logic                   play_pause,
    output logic                   stop,
    output logic                   mute,
    output logic                   loop_en
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TRK_W-1:0]  TRK_LAST  = TRK_W'(NUM_TRACKS - 1);

    state_t state, state_n;

    logic [BTN_W-1:0]  bot_prev;
    cmd_t              cmd, cmd_raw;
    logic [IDX_W-1:0]  note_idx, idx_n;
    logic [TRK_W-1:0]  track_n, trk_inc, trk_dec;
    logic [PER_W-1:0]  period_q, rom_period;
    logic [DUR_W-1:0]  dur_rem, rom_dur;
    logic [TICK_W-1:0] tick_cnt;
    logic              resume_fetch;
    logic              note_done, run, load_note, tone_q;

    assign rom_period = rom_data[PER_W+DUR_W-1:DUR_W];
    assign rom_dur    = rom_data[DUR_W-1:0];

    assign trk_inc = (track == TRK_LAST) ? '0 : track + TRK_W'(1);
    assign trk_dec = (track == '0) ? TRK_LAST : track - TRK_W'(1);

    assign play_pause = (state == ST_FETCH) || (state == ST_LOAD)
                     || (state == ST_NOTE);
    assign stop       = (state == ST_STOPPED);

    // A code fires once, on the cycle its value first differs from last cycle.
    always_comb begin
        cmd_raw = CMD_IDLE;
        if (bot != bot_prev) begin
            cmd_raw.do_mute = (bot == BTN_W'(CMD_MUTE));
            cmd_raw.do_play = (bot == BTN_W'(CMD_PLAY));
            cmd_raw.do_next = (bot == BTN_W'(CMD_NEXT));
            cmd_raw.do_stop = (bot == BTN_W'(CMD_STOP));
            cmd_raw.do_prev = (bot == BTN_W'(CMD_PREV));
            cmd_raw.do_loop = (bot == BTN_W'(CMD_LOOP));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bot_prev <= BTN_W'(CMD_NONE);
            cmd      <= CMD_IDLE;
        end else begin
            bot_prev <= bot;
            cmd      <= cmd_raw;
        end
    end

    always_comb begin
        note_done = (state == ST_NOTE) && (tick_cnt == TICK_LAST)
                 && (dur_rem == DUR_W'(1));
        state_n = state;
        track_n = track;
        idx_n   = note_idx;

        unique case (state)
            ST_STOPPED: begin
                idx_n = '0;
                if (cmd.do_play) state_n = ST_FETCH;
            end
            ST_FETCH: state_n = ST_LOAD;
            ST_LOAD: begin
                if (rom_dur == '0) begin
                    idx_n   = '0;
                    state_n = loop_en ? ST_FETCH : ST_STOPPED;
                end else begin
                    state_n = ST_NOTE;
                end
            end
            ST_NOTE: begin
                if (note_done) begin
                    // last slot of the table ends the track instead of wrapping
                    if (&note_idx) begin
                        idx_n   = '0;
                        state_n = loop_en ? ST_FETCH : ST_STOPPED;
                    end else begin
                        idx_n   = note_idx + IDX_W'(1);
                        state_n = ST_FETCH;
                    end
                end
            end
            ST_PAUSED: begin
                if (cmd.do_play)
                    state_n = resume_fetch ? ST_FETCH : ST_NOTE;
            end
            default: state_n = ST_STOPPED;
        endcase

        if (cmd.do_stop) begin
            state_n = ST_STOPPED;
            idx_n   = '0;
        end else if (cmd.do_next || cmd.do_prev) begin
            track_n = cmd.do_next ? trk_inc : trk_dec;
            idx_n   = '0;
            if ((state == ST_STOPPED) || (state == ST_PAUSED))
                state_n = ST_STOPPED;
            else
                state_n = ST_FETCH;
        end else if (cmd.do_play && play_pause) begin
            state_n = ST_PAUSED;
            idx_n   = note_idx;
        end

        // counters only advance on cycles that stay in NOTE, so a pause
        // decided in the final cycle of a note cannot lose its ending
        run       = (state == ST_NOTE) && (state_n == ST_NOTE);
        load_note = (state == ST_LOAD) && (state_n == ST_NOTE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_STOPPED;
            track        <= '0;
            note_idx     <= '0;
            rom_addr     <= '0;
            period_q     <= '0;
            dur_rem      <= '0;
            tick_cnt     <= '0;
            resume_fetch <= 1'b0;
            mute         <= 1'b0;
            loop_en      <= 1'b0;
            buzzer       <= 1'b0;
        end else begin
            state    <= state_n;
            track    <= track_n;
            note_idx <= idx_n;

            if (state_n == ST_FETCH)
                rom_addr <= {track_n, idx_n};

            if (cmd.do_mute) mute    <= ~mute;
            if (cmd.do_loop) loop_en <= ~loop_en;

            if ((state_n == ST_PAUSED) && (state != ST_PAUSED))
                resume_fetch <= (state != ST_NOTE);

            if (load_note) begin
                period_q <= rom_period;
                dur_rem  <= rom_dur;
                tick_cnt <= '0;
            end else if (run) begin
                if (tick_cnt == TICK_LAST) begin
                    tick_cnt <= '0;
                    dur_rem  <= dur_rem - DUR_W'(1);
                end else begin
                    tick_cnt <= tick_cnt + TICK_W'(1);
                end
            end

            buzzer <= tone_q & ~mute & (state == ST_NOTE);
        end
    end

    tone_gen #(
        .PER_W (PER_W)
    ) u_tone (
        .clock  (clock),
        .reset  (reset),
        .load   (load_note),
        .enable (run),
        .period (load_note ? rom_period : period_q),
        .tone_q (tone_q)
    );

endmodule

// File: tb/tb_mp3_seq_player.sv
// Directed bench for mp3_seq_player with TICK_DIV=4 and a 1-clock ROM model.
module tb_mp3_seq_player;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  bot   = 8'hFF;
    logic [7:0]  rom_addr;
    logic [23:0] rom_data;
    logic        buzzer;
    logic [1:0]  track;
    logic        play_pause;
    logic        stop;
    logic        mute;
    logic        loop_en;

    logic [23:0] rom [256];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clock = ~clock;

    always_ff @(posedge clock) rom_data <= rom[rom_addr];

    mp3_seq_player #(
        .NUM_TRACKS (4),
        .TRK_W      (2),
        .IDX_W      (6),
        .PER_W      (18),
        .DUR_W      (6),
        .TICK_DIV   (4),
        .BTN_W      (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bot        (bot),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .buzzer     (buzzer),
        .track      (track),
        .play_pause (play_pause),
        .stop       (stop),
        .mute       (mute),
        .loop_en    (loop_en)
    );

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic press(input logic [7:0] code);
        bot = code;
        tick();
        bot = 8'hFF;
    endtask

    task automatic wait_stop(input int limit, output bit ok);
        int n;
        n = 0;
        while (stop !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        ok = (stop === 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick(); tick();
        checks++;
        if ({play_pause, stop, buzzer} !== 3'b010) begin
            failures++;
            $display("FAIL reset_status: got pp/stop/bz=%b required 010",
                     {play_pause, stop, buzzer});
        end
        checks++;
        if ({mute, loop_en, track, rom_addr} !== 12'h000) begin
            failures++;
            $display("FAIL reset_regs: got %h required 000",
                     {mute, loop_en, track, rom_addr});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_play_track0();
        logic [7:0]  a [21];
        logic [20:0] bz_v, bz_exp;
        logic [20:0] st_v;
        logic [20:0] pp_v;
        bz_v = '0; st_v = '0; pp_v = '0;
        bz_exp = 21'b0;
        bz_exp[8] = 1'b1; bz_exp[9] = 1'b1; bz_exp[10] = 1'b1;
        press(8'h01);
        for (int c = 2; c <= 20; c++) begin
            tick();
            a[c] = rom_addr;
            bz_v[c] = buzzer;
            st_v[c] = stop;
            pp_v[c] = play_pause;
        end
        checks++;
        if ({a[2], pp_v[2], st_v[2]} !== {8'h00, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL play_fetch0: addr=%h pp=%b stop=%b required 00 1 0",
                     a[2], pp_v[2], st_v[2]);
        end
        checks++;
        if (a[11] !== 8'h00 || a[12] !== 8'h01) begin
            failures++;
            $display("FAIL play_addr1: got %h,%h required 00,01", a[11], a[12]);
        end
        checks++;
        if (a[17] !== 8'h01 || a[18] !== 8'h02) begin
            failures++;
            $display("FAIL play_addr2: got %h,%h required 01,02", a[17], a[18]);
        end
        checks++;
        if (bz_v !== bz_exp) begin
            failures++;
            $display("FAIL play_buzzer: got %b required %b", bz_v, bz_exp);
        end
        checks++;
        if ({st_v[19], st_v[20], pp_v[20]} !== 3'b010) begin
            failures++;
            $display("FAIL play_end: stop19/stop20/pp20=%b required 010",
                     {st_v[19], st_v[20], pp_v[20]});
        end
    endtask

    task automatic test_pause();
        logic [7:0] a [9];
        logic [8:0] bz_v;
        int         bad;
        bit         ok;
        bz_v = '0;
        bad  = 0;
        press(8'h01);
        tick();
        checks++;
        if (rom_addr !== 8'h00) begin
            failures++;
            $display("FAIL restart_idx0: addr=%h required 00", rom_addr);
        end
        tick(); tick(); tick();
        press(8'h01);
        tick();
        checks++;
        if ({play_pause, stop, buzzer} !== 3'b000) begin
            failures++;
            $display("FAIL pause_status: pp/stop/bz=%b required 000",
                     {play_pause, stop, buzzer});
        end
        for (int i = 0; i < 19; i++) begin
            tick();
            if (buzzer !== 1'b0 || rom_addr !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL pause_hold: %0d bad cycles required 0", bad);
        end
        press(8'h01);
        tick();
        for (int r = 3; r <= 8; r++) begin
            tick();
            a[r] = rom_addr;
            bz_v[r] = buzzer;
        end
        checks++;
        if (bz_v[8:3] !== 6'b001110) begin
            failures++;
            $display("FAIL resume_buzzer: got %b required 001110", bz_v[8:3]);
        end
        checks++;
        if (a[7] !== 8'h00 || a[8] !== 8'h01) begin
            failures++;
            $display("FAIL resume_timing: got %h,%h required 00,01", a[7], a[8]);
        end
        wait_stop(50, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL pause_track_end: stop=%b required 1", stop);
        end
    endtask

    task automatic test_track_select();
        bit ok;
        press(8'h04); tick();
        checks++;
        if (track !== 2'd3) begin
            failures++;
            $display("FAIL prev_wrap: track=%0d required 3", track);
        end
        press(8'h02); tick();
        checks++;
        if (track !== 2'd0 || stop !== 1'b1) begin
            failures++;
            $display("FAIL next_wrap: track=%0d stop=%b required 0 1", track, stop);
        end
        press(8'h04); tick();
        checks++;
        if (track !== 2'd3) begin
            failures++;
            $display("FAIL prev_again: track=%0d required 3", track);
        end
        press(8'h02); tick();
        press(8'h02); tick();
        checks++;
        if (track !== 2'd1) begin
            failures++;
            $display("FAIL select_t1: track=%0d required 1", track);
        end
        press(8'h01);
        tick(); tick(); tick(); tick(); tick();
        press(8'h02);
        tick();
        checks++;
        if ({track, rom_addr, play_pause} !== {2'd2, 8'h80, 1'b1}) begin
            failures++;
            $display("FAIL next_playing: track=%0d addr=%h pp=%b required 2 80 1",
                     track, rom_addr, play_pause);
        end
        wait_stop(60, ok);
        checks++;
        if (!ok || track !== 2'd2) begin
            failures++;
            $display("FAIL t2_end: stop=%b track=%0d required 1 2", stop, track);
        end
    endtask

    task automatic test_loop();
        logic [7:0] seq [8];
        logic [7:0] prev;
        logic [7:0] exp [6];
        int         n;
        int         bad;
        n = 0; bad = 0;
        exp[0] = 8'h80; exp[1] = 8'h81; exp[2] = 8'h82;
        exp[3] = 8'h80; exp[4] = 8'h81; exp[5] = 8'h82;
        press(8'h05); tick();
        checks++;
        if (loop_en !== 1'b1) begin
            failures++;
            $display("FAIL loop_on: loop_en=%b required 1", loop_en);
        end
        prev = rom_addr;
        press(8'h01);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rom_addr !== prev && n < 8) begin
                seq[n] = rom_addr;
                n++;
            end
            prev = rom_addr;
            if (stop !== 1'b0) bad++;
        end
        for (int i = 0; i < 6; i++)
            if (i >= n || seq[i] !== exp[i]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL loop_seq: %0d errors in %0d addr changes required 0",
                     bad, n);
        end
        press(8'h03);
        tick();
        checks++;
        if (stop !== 1'b1) begin
            failures++;
            $display("FAIL stop_cmd: stop=%b required 1", stop);
        end
        tick();
        checks++;
        if ({buzzer, play_pause} !== 2'b00) begin
            failures++;
            $display("FAIL stop_quiet: bz/pp=%b required 00", {buzzer, play_pause});
        end
        press(8'h05); tick();
        checks++;
        if (loop_en !== 1'b0) begin
            failures++;
            $display("FAIL loop_off: loop_en=%b required 0", loop_en);
        end
    endtask

    task automatic test_hold_and_mute();
        int s;
        int ones;
        int bad;
        bit ok;
        ones = 0; bad = 0;
        press(8'h04); tick();
        checks++;
        if (track !== 2'd1) begin
            failures++;
            $display("FAIL hold_sel: track=%0d required 1", track);
        end
        s = cyc;
        bot = 8'h01;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (buzzer === 1'b1) ones++;
        end
        checks++;
        if ({play_pause, rom_addr} !== {1'b1, 8'h40} || ones == 0) begin
            failures++;
            $display("FAIL hold_single: pp=%b addr=%h ones=%0d required 1 40 >0",
                     play_pause, rom_addr, ones);
        end
        press(8'h00);
        tick();
        checks++;
        if (mute !== 1'b1) begin
            failures++;
            $display("FAIL mute_on: mute=%b required 1", mute);
        end
        while (cyc < s + 83) begin
            tick();
            if (buzzer !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || rom_addr !== 8'h40) begin
            failures++;
            $display("FAIL mute_quiet: loud=%0d addr=%h required 0 40", bad, rom_addr);
        end
        tick();
        checks++;
        if (rom_addr !== 8'h41) begin
            failures++;
            $display("FAIL mute_timing: addr=%h required 41", rom_addr);
        end
        press(8'h00); tick();
        checks++;
        if (mute !== 1'b0) begin
            failures++;
            $display("FAIL mute_off: mute=%b required 0", mute);
        end
        wait_stop(40, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL t1_end: stop=%b required 1", stop);
        end
    endtask

    task automatic test_reset_mid();
        press(8'h00); tick();
        press(8'h05); tick();
        press(8'h01);
        tick(); tick(); tick(); tick(); tick();
        checks++;
        if (play_pause !== 1'b1 || {mute, loop_en} !== 2'b11) begin
            failures++;
            $display("FAIL pre_reset: pp=%b mute/loop=%b required 1 11",
                     play_pause, {mute, loop_en});
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({play_pause, stop, buzzer, mute, loop_en, track, rom_addr}
            !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00}) begin
            failures++;
            $display("FAIL reset_mid: pp=%b stop=%b bz=%b mute=%b loop=%b trk=%0d addr=%h required 0 1 0 0 0 0 00",
                     play_pause, stop, buzzer, mute, loop_en, track, rom_addr);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_full_track();
        logic [7:0] prev;
        bit         saw_ff;
        bit         wrapped;
        int         n;
        saw_ff = 1'b0; wrapped = 1'b0; n = 0;
        press(8'h04); tick();
        press(8'h01);
        tick();
        prev = rom_addr;
        while (stop !== 1'b1 && n < 600) begin
            tick();
            n++;
            if (rom_addr === 8'hFF) saw_ff = 1'b1;
            if (prev === 8'hFF && rom_addr !== 8'hFF) wrapped = 1'b1;
            prev = rom_addr;
        end
        checks++;
        if (stop !== 1'b1 || track !== 2'd3) begin
            failures++;
            $display("FAIL full_end: stop=%b track=%0d after %0d cycles required 1 3",
                     stop, track, n);
        end
        checks++;
        if (!saw_ff || wrapped || rom_addr !== 8'hFF) begin
            failures++;
            $display("FAIL full_nowrap: saw_ff=%b wrapped=%b addr=%h required 1 0 ff",
                     saw_ff, wrapped, rom_addr);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 24'h0;
        rom[8'h00] = {18'd3, 6'd2};
        rom[8'h01] = {18'd0, 6'd1};
        rom[8'h40] = {18'd5, 6'd20};
        rom[8'h41] = {18'd4, 6'd1};
        rom[8'h80] = {18'd2, 6'd1};
        rom[8'h81] = {18'd0, 6'd1};
        for (int i = 8'hC0; i <= 8'hFF; i++) rom[i] = {18'd1, 6'd1};

        test_reset();
        test_play_track0();
        test_pause();
        test_track_select();
        test_loop();
        test_hold_and_mute();
        test_reset_mid();
        test_full_track();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
